// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access width codes,
// FSM state encoding and the memory bus width in bytes.
package lsu_pkg;

    localparam int MEM_BYTES = 8;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } width_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for one access: byte enables and store
// data for both beats, split detection, and extended load data.
// Ports: width/off/sign/wdata describe the access; rdata is
// {beat1, beat0} read data; be0/be1, wdata0/wdata1, split, rdata_ext out.
module lsu_lane_align
    import lsu_pkg::*;
#(
    localparam int LANE_W = MEM_BYTES * 8
) (
    input  logic [1:0]          width,
    input  logic [2:0]          off,
    input  logic                sign,
    input  logic [LANE_W-1:0]   wdata,
    input  logic [2*LANE_W-1:0] rdata,
    output logic [7:0]          be0,
    output logic [7:0]          be1,
    output logic [LANE_W-1:0]   wdata0,
    output logic [LANE_W-1:0]   wdata1,
    output logic [LANE_W-1:0]   rdata_ext,
    output logic                split
);

    logic [15:0]         byte_mask;
    logic [15:0]         be_wide;
    logic [LANE_W-1:0]   data_mask;
    logic [2*LANE_W-1:0] wd_wide;
    logic [LANE_W-1:0]   rd_low;

    // sign == 0 selects sign extension, sign == 1 zero extension
    always_comb begin
        byte_mask = 16'h0000;
        data_mask = '0;
        rdata_ext = '0;
        rd_low    = LANE_W'(rdata >> {off, 3'b000});
        case (width_e'(width))
            BYTE: begin
                byte_mask = 16'h0001;
                data_mask = 64'h0000_0000_0000_00FF;
                rdata_ext = {{56{~sign & rd_low[7]}}, rd_low[7:0]};
            end
            HALF: begin
                byte_mask = 16'h0003;
                data_mask = 64'h0000_0000_0000_FFFF;
                rdata_ext = {{48{~sign & rd_low[15]}}, rd_low[15:0]};
            end
            WORD: begin
                byte_mask = 16'h000F;
                data_mask = 64'h0000_0000_FFFF_FFFF;
                rdata_ext = {{32{~sign & rd_low[31]}}, rd_low[31:0]};
            end
            DOUBLE: begin
                byte_mask = 16'h00FF;
                data_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                rdata_ext = rd_low;
            end
            default: ;
        endcase
        // upper half of the wide vectors is what spills into beat1
        be_wide = byte_mask << off;
        wd_wide = {{LANE_W{1'b0}}, wdata & data_mask} << {off, 3'b000};
    end

    assign be0    = be_wide[7:0];
    assign be1    = be_wide[15:8];
    assign wdata0 = wd_wide[LANE_W-1:0];
    assign wdata1 = wd_wide[2*LANE_W-1:LANE_W];
    assign split  = |be_wide[15:8];

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one core request at a time, issues one or two
// aligned 8-byte memory beats, and returns extended load data.
// Ports: clk/rst, req_* core request, rsp_* completion, mem_* memory bus.
module load_store_unit #(
    parameter int REG_WIDTH = 64,
    parameter int MEM_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_read,
    input  logic                   req_write,
    input  logic                   req_sign,
    input  logic [1:0]             req_width,
    input  logic [REG_WIDTH-1:0]   req_addr,
    input  logic [REG_WIDTH-1:0]   req_wdata,
    output logic                   rsp_valid,
    output logic [REG_WIDTH-1:0]   rsp_rdata,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_we,
    output logic [REG_WIDTH-1:0]   mem_addr,
    output logic [MEM_BYTES-1:0]   mem_be,
    output logic [8*MEM_BYTES-1:0] mem_wdata,
    input  logic                   mem_rsp_valid,
    input  logic [8*MEM_BYTES-1:0] mem_rdata
);

    import lsu_pkg::*;

    state_e                 state_q, state_d;
    logic                   load_q, load_d;
    logic                   we_q, we_d;
    logic                   sign_q, sign_d;
    logic [1:0]             width_q, width_d;
    logic [REG_WIDTH-1:0]   addr_q, addr_d;
    logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
    logic [REG_WIDTH-1:0]   beat0_q, beat0_d;
    logic [REG_WIDTH-1:0]   rdata_q, rdata_d;

    logic [7:0]             be0, be1;
    logic [63:0]            wdata0, wdata1;
    logic [63:0]            rdata_ext;
    logic [127:0]           align_rdata;
    logic                   split;
    logic [REG_WIDTH-1:0]   base_addr;

    assign base_addr = {addr_q[REG_WIDTH-1:3], 3'b000};

    // in WAIT0 the live response is beat0; in WAIT1 it is beat1
    assign align_rdata = (state_q == WAIT1) ? {mem_rdata, beat0_q}
                                            : {64'b0, mem_rdata};

    lsu_lane_align u_align (
        .width     (width_q),
        .off       (addr_q[2:0]),
        .sign      (sign_q),
        .wdata     (wdata_q),
        .rdata     (align_rdata),
        .be0       (be0),
        .be1       (be1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .rdata_ext (rdata_ext),
        .split     (split)
    );

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        we_d    = we_q;
        sign_d  = sign_q;
        width_d = width_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        beat0_d = beat0_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // read+write together behaves as a store
                    load_d  = req_read & ~req_write;
                    we_d    = req_write;
                    sign_d  = req_sign;
                    width_d = req_width;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_read || req_write) begin
                        state_d = REQ0;
                    end else begin
                        state_d = DONE;
                        rdata_d = '0;
                    end
                end
            end
            REQ0: begin
                if (mem_req_ready) state_d = WAIT0;
            end
            WAIT0: begin
                if (mem_rsp_valid) begin
                    beat0_d = mem_rdata;
                    if (split) begin
                        state_d = REQ1;
                    end else begin
                        state_d = DONE;
                        rdata_d = load_q ? rdata_ext : '0;
                    end
                end
            end
            REQ1: begin
                if (mem_req_ready) state_d = WAIT1;
            end
            WAIT1: begin
                if (mem_rsp_valid) begin
                    state_d = DONE;
                    rdata_d = load_q ? rdata_ext : '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_be        = '0;
        mem_wdata     = '0;
        case (state_q)
            REQ0: begin
                mem_req_valid = 1'b1;
                mem_we        = we_q;
                mem_addr      = base_addr;
                mem_be        = be0;
                mem_wdata     = we_q ? wdata0 : '0;
            end
            REQ1: begin
                mem_req_valid = 1'b1;
                mem_we        = we_q;
                // wraps modulo 2^64 on the top word
                mem_addr      = base_addr + REG_WIDTH'(8);
                mem_be        = be1;
                mem_wdata     = we_q ? wdata1 : '0;
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            width_q <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            we_q    <= we_d;
            sign_q  <= sign_d;
            width_q <= width_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat0_q <= beat0_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory,
// scoreboard of expected load data, and a 1-cycle memory responder.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_read, req_write, req_sign;
    logic [1:0]  req_width;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_sign      (req_sign),
        .req_width     (req_width),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    typedef struct {
        bit        we;
        bit [63:0] addr;
        bit [7:0]  be;
        bit [63:0] wdata;
    } beat_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    beat_t       beats[$];
    bit [63:0]   sb[$];
    bit [63:0]   mem [bit [63:0]];
    bit [7:0]    ref_mem [bit [63:0]];
    bit          mute_en = 1'b0;
    bit [63:0]   mute_addr = '0;
    int          inject_req = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit [63:0] ref_load(input bit [63:0] a,
                                           input bit [1:0] w,
                                           input bit sgn);
        int        n;
        bit [63:0] v;
        bit [63:0] k;
        n = 1 << w;
        v = '0;
        for (int i = 0; i < n; i++) begin
            k = a + 64'(i);
            if (ref_mem.exists(k)) v[8*i+:8] = ref_mem[k];
        end
        if (w != 2'd3 && !sgn && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i+:8] = 8'hFF;
        return v;
    endfunction

    // memory responder: one response the cycle after each accepted beat
    initial begin
        beat_t     b;
        bit        hit;
        bit [63:0] w;
        int        inject_seen;
        inject_seen   = 0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(negedge clk);
            hit = mem_req_valid && mem_req_ready && !rst;
            if (hit) begin
                b.we    = mem_we;
                b.addr  = mem_addr;
                b.be    = mem_be;
                b.wdata = mem_wdata;
                beats.push_back(b);
            end
            @(posedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            if (hit && !(mute_en && b.addr == mute_addr)) begin
                if (b.we) begin
                    w = mem.exists(b.addr) ? mem[b.addr] : '0;
                    for (int i = 0; i < 8; i++)
                        if (b.be[i]) w[8*i+:8] = b.wdata[8*i+:8];
                    mem[b.addr] = w;
                    mem_rdata = {$urandom, $urandom};
                end else begin
                    mem_rdata = mem.exists(b.addr) ? mem[b.addr] : '0;
                end
                mem_rsp_valid = 1'b1;
            end else if (inject_req != inject_seen) begin
                inject_seen   = inject_req;
                mem_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
                mem_rsp_valid = 1'b1;
            end
        end
    end

    task automatic lsu_op(input bit rd, input bit wr, input bit sgn,
                          input bit [1:0] w, input bit [63:0] a,
                          input bit [63:0] wd, input int stall);
        int        n, cnt, lat, nbeats;
        bit        split;
        bit [63:0] exp;
        bit [63:0] s_addr, s_wdata;
        bit [7:0]  s_be;
        bit        s_we;
        n     = 1 << w;
        split = (int'(a[2:0]) + n) > 8;
        if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[a + 64'(i)] = wd[8*i+:8];
            exp = '0;
        end else if (rd) begin
            exp = ref_load(a, w, sgn);
        end else begin
            exp = '0;
        end
        sb.push_back(exp);
        lat    = (rd || wr) ? ((split ? 5 : 3) + stall) : 0;
        nbeats = (rd || wr) ? (split ? 2 : 1) : 0;
        beats.delete();
        if (stall > 0) mem_req_ready = 1'b0;
        req_valid = 1'b1;
        req_read  = rd;
        req_write = wr;
        req_sign  = sgn;
        req_width = w;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        chk("req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
        s_addr = '0; s_wdata = '0; s_be = '0; s_we = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", mem_req_valid, 1);
            chk("stall_req_ready", req_ready, 0);
            if (i == 0) begin
                s_addr = mem_addr; s_wdata = mem_wdata;
                s_be = mem_be; s_we = mem_we;
            end else begin
                chk("stall_addr", mem_addr, s_addr);
                chk("stall_be", mem_be, s_be);
                chk("stall_we", mem_we, s_we);
                chk("stall_wdata", mem_wdata, s_wdata);
            end
        end
        if (stall > 0) begin
            @(posedge clk);
            #1;
            mem_req_ready = 1'b1;
        end
        cnt = stall;
        do begin
            @(negedge clk);
            cnt++;
        end while (!rsp_valid && cnt < 40);
        exp = sb.pop_front();
        if (!rsp_valid) begin
            chk("rsp_timeout", rsp_valid, 1);
        end else begin
            chk("rsp_rdata", rsp_rdata, exp);
            if (rd || wr) chk("latency", 64'(cnt), 64'(lat));
            else chk("noop_latency", 64'(cnt <= 2), 1);
            chk("beat_count", 64'(beats.size()), 64'(nbeats));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input int idx, input bit we, input bit [63:0] a,
                            input bit [7:0] be, input bit [63:0] wd);
        if (beats.size() <= idx) begin
            chk("beat_missing", 64'(beats.size()), 64'(idx + 1));
        end else begin
            chk("beat_we", beats[idx].we, we);
            chk("beat_addr", beats[idx].addr, a);
            chk("beat_be", beats[idx].be, be);
            chk("beat_wdata", beats[idx].wdata, wd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_sign = 1'b0; req_width = 2'd0;
        req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        lsu_op(0, 1, 0, 2'd2, 64'h10, 64'hDEAD_BEEF, 0);
        chk_beat(0, 1, 64'h10, 8'h0F, 64'h0000_0000_DEAD_BEEF);

        lsu_op(0, 1, 0, 2'd0, 64'h13, 64'h80, 0);
        chk_beat(0, 1, 64'h10, 8'h08, 64'h0000_0000_8000_0000);
        lsu_op(1, 0, 0, 2'd0, 64'h13, 64'h0, 0);
        chk("ldb_sext", rsp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        lsu_op(1, 0, 1, 2'd0, 64'h13, 64'h0, 0);
        chk("ldb_zext", rsp_rdata, 64'h0000_0000_0000_0080);
        repeat (2) @(posedge clk);
        #1;
        chk("rdata_hold", rsp_rdata, 64'h80);
        lsu_op(1, 0, 0, 2'd2, 64'h10, 64'h0, 0);

        lsu_op(0, 1, 0, 2'd3, 64'h0D, 64'h1122_3344_5566_7788, 0);
        chk_beat(0, 1, 64'h08, 8'hE0, 64'h6677_8800_0000_0000);
        chk_beat(1, 1, 64'h10, 8'h1F, 64'h0000_0011_2233_4455);
        lsu_op(1, 0, 0, 2'd3, 64'h0D, 64'h0, 0);
        chk("ldd_split", rsp_rdata, 64'h1122_3344_5566_7788);
        lsu_op(1, 0, 0, 2'd1, 64'h0F, 64'h0, 0);
        lsu_op(1, 0, 1, 2'd2, 64'h0E, 64'h0, 0);

        lsu_op(0, 1, 0, 2'd1, 64'h20, 64'hCAFE, 4);
        lsu_op(1, 0, 0, 2'd1, 64'h20, 64'h0, 0);

        lsu_op(1, 1, 0, 2'd2, 64'h30, 64'h1357_9BDF, 0);
        chk_beat(0, 1, 64'h30, 8'h0F, 64'h0000_0000_1357_9BDF);
        lsu_op(1, 0, 1, 2'd2, 64'h30, 64'h0, 0);

        lsu_op(0, 1, 0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA55A, 0);
        chk_beat(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 8'h80, 64'h5A00_0000_0000_0000);
        chk_beat(1, 1, 64'h0, 8'h01, 64'h0000_0000_0000_00A5);
        lsu_op(1, 0, 0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0);
        chk("wrap_load", rsp_rdata, 64'hFFFF_FFFF_FFFF_A55A);

        lsu_op(0, 0, 0, 2'd3, 64'h40, 64'h1234, 0);
        chk("noop_rdata", rsp_rdata, 0);

        // abandon a split load in WAIT1, then a stale response arrives
        mute_en   = 1'b1;
        mute_addr = 64'h10;
        beats.delete();
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        req_sign = 1'b0; req_width = 2'd3; req_addr = 64'h0D;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_read = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (beats.size() < 2 && cnt < 20);
        chk("rst_test_beats", 64'(beats.size()), 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wait1_mem_valid", mem_req_valid, 0);
        chk("wait1_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        inject_req++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_rsp", rsp_valid, 0);
            chk("post_rst_ready", req_ready, 1);
            chk("post_rst_mem", mem_req_valid, 0);
        end
        chk("post_rst_rdata", rsp_rdata, 0);
        mute_en = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 40; t++) begin
            int        op;
            bit [1:0]  w;
            bit [63:0] a;
            op = $urandom_range(0, 3);
            w  = 2'($urandom_range(0, 3));
            a  = 64'($urandom_range(0, 63));
            lsu_op(op[0], op[1], 1'($urandom_range(0, 1)), w, a,
                   {$urandom, $urandom}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
